pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/pipe_cla_adder_if.sv | 27 ++
 rtl/pipe_cla_adder.sv | 120 ++++++++++++
 tb/tb_pipe_cla_adder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_cla_adder_if.sv
// rtl/pipe_cla_adder_if.sv - operand/result handshake bundle for pipe_cla_adder
// master drives operands and out_ready; slave is the adder.
interface pipe_cla_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined 4-bit-group carry-look-ahead adder/subtractor
// One group per stage; macro PIPE_CLA_SAT_EN clamps overflowing results.
module pipe_cla_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_cla_adder_if.slave  bus
);
   localparam int NSTG = WIDTH / 4;

   logic en;

   genvar k;
   generate
      for (k = 0; k < NSTG; k++) begin : stg
         // Operand bits still to be summed shrink by one group per stage.
         localparam int SW = WIDTH - 4 * k;

         logic [SW-1:0]  a_src;
         logic [SW-1:0]  b_src;
         logic           c_src;
         logic           v_src;
         logic [3:0]     p;
         logic [3:0]     g;
         logic [3:0]     gs;
         logic           c1, c2, c3, c4;
         logic [4*k+3:0] s_nxt;
         logic [4*k+3:0] s_q;
         logic           v_q;
         logic           c_q;

         if (k == 0) begin : src
            assign a_src = bus.a;
            assign b_src = bus.sub ? ~bus.b : bus.b;
            assign c_src = bus.sub | bus.cin;
            assign v_src = bus.in_valid;
            assign s_nxt = gs;
         end else begin : src
            assign a_src = stg[k-1].fwd.a_q;
            assign b_src = stg[k-1].fwd.b_q;
            assign c_src = stg[k-1].c_q;
            assign v_src = stg[k-1].v_q;
            assign s_nxt = {gs, stg[k-1].s_q};
         end

         assign p  = a_src[3:0] ^ b_src[3:0];
         assign g  = a_src[3:0] & b_src[3:0];
         assign c1 = g[0] | (p[0] & c_src);
         assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_src);
         assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & c_src);
         assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]) | (&p & c_src);
         assign gs = p ^ {c3, c2, c1, c_src};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               c_q <= 1'b0;
               s_q <= '0;
            end else if (en) begin
               v_q <= v_src;
               c_q <= c4;
               s_q <= s_nxt;
            end
         end

         if (k < NSTG - 1) begin : fwd
            logic [SW-5:0] a_q;
            logic [SW-5:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_q <= '0;
                  b_q <= '0;
               end else if (en) begin
                  a_q <= a_src[SW-1:4];
                  b_q <= b_src[SW-1:4];
               end
            end
         end else begin : lst
            logic ovf_q;
`ifdef PIPE_CLA_SAT_EN
            logic neg_q;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  ovf_q <= 1'b0;
`ifdef PIPE_CLA_SAT_EN
                  neg_q <= 1'b0;
`endif
               end else if (en) begin
                  ovf_q <= c3 ^ c4;
`ifdef PIPE_CLA_SAT_EN
                  neg_q <= a_src[3];
`endif
               end
            end
         end
      end
   endgenerate

   assign en            = !stg[NSTG-1].v_q | bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = stg[NSTG-1].v_q;
   assign bus.cout      = stg[NSTG-1].c_q;
   assign bus.ovf       = stg[NSTG-1].lst.ovf_q;

`ifdef PIPE_CLA_SAT_EN
   // Overflow direction follows the sign of a: negative a can only underflow.
   logic sat_neg;
   assign sat_neg = stg[NSTG-1].lst.neg_q;
   assign bus.sum = stg[NSTG-1].lst.ovf_q ? {sat_neg, {(WIDTH-1){~sat_neg}}}
                                          : stg[NSTG-1].s_q;
`else
   assign bus.sum = stg[NSTG-1].s_q;
`endif
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - scoreboard bench for pipe_cla_adder (WIDTH=16)
module tb_pipe_cla_adder;
   localparam int W    = 16;
   localparam int NSTG = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
      bit           lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pipe_cla_adder_if #(.WIDTH(W)) bus();

   pipe_cla_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   bit   rmode     = 1'b0;
   bit   lat_mode  = 1'b1;
   int   stall_gen = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o; e.acc = 0; e.lat = 1'b0;
      return e;
   endfunction

   // Reference: true signed/unsigned arithmetic, range-checked.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t   e;
      longint sa, sb, rs, ru, lim;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = longint'(1) << (W - 1);
      if (sub) begin
         rs     = sa - sb;
         ru     = longint'(a) - longint'(b);
         e.cout = (a >= b);
      end else begin
         rs     = sa + sb + longint'(cin);
         ru     = longint'(a) + longint'(b) + longint'(cin);
         e.cout = (ru >= 2 * lim);
      end
      e.sum = ru[W-1:0];
      e.ovf = (rs >= lim) || (rs < -lim);
`ifdef PIPE_CLA_SAT_EN
      if (e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input exp_t e);
      bit done;
      done = 1'b0;
      @(posedge clk); #1;
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.acc = cyc + 1;
            e.lat = lat_mode;
            q.push_back(e);
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stuck at 0, required 1");
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      send_exp(a, b, cin, sub, model(a, b, cin, sub));
   endtask

   task automatic send_rand();
      logic [W-1:0] a, b;
      a = W'($urandom());
      b = W'($urandom());
      if ($urandom_range(0, 3) == 0) a = {a[W-1], {(W-1){a[0]}}};
      send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      idle(1);
      for (int t = 0; t < 3000 && q.size() != 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // out_ready driver: always ready, random, or a 3-cycle stall on request
   initial begin
      int seen;
      int hold;
      seen = 0;
      hold = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_gen != seen) begin
            seen = stall_gen;
            hold = 3;
         end
         if (hold > 0) begin
            bus.out_ready = 1'b0;
            hold--;
         end else begin
            bus.out_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor: compares each delivered result against the scoreboard head
   initial begin
      exp_t         e;
      bit           stalled;
      logic [W-1:0] ps;
      logic         pc, po;
      stalled = 1'b0;
      ps = '0; pc = 1'b0; po = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled)
               chk("stall_stable", {bus.out_valid, bus.sum, bus.cout, bus.ovf},
                                   {1'b1, ps, pc, po});
            if (bus.out_valid && !bus.out_ready) begin
               chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
               stalled = 1'b1;
               ps = bus.sum; pc = bus.cout; po = bus.ovf;
            end else begin
               stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_result: sum=%0h with empty scoreboard", bus.sum);
               end else begin
                  e = q.pop_front();
                  chk("sum", 64'(bus.sum), 64'(e.sum));
                  chk("cout", 64'(bus.cout), 64'(e.cout));
                  chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                  if (e.lat) chk("latency", 64'(cyc + 1 - e.acc), 64'(NSTG));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_sum", 64'(bus.sum), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk); #2;
      rst_n = 1'b1;

      // Directed corners, back to back, exact latency expected
      lat_mode = 1'b1;
      rmode    = 1'b0;
      send_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
`ifdef PIPE_CLA_SAT_EN
      send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h7FFF, 1'b0, 1'b1));
      send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b1, 1'b1));
      send_exp(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h8000, 1'b1, 1'b1));
`else
      send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
      send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
      send_exp(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1));
`endif
      send_exp(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
      send_exp(16'h1234, 16'h0FFF, 1'b1, 1'b0, mk(16'h2234, 1'b0, 1'b0));
      send_exp(16'h0007, 16'h0007, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
      idle(3);
      send_exp(16'h00FF, 16'h0F01, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0));
      drain();

      // 8 back-to-back ops with a 3-cycle consumer stall in the middle
      lat_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_rand();
         if (i == 4) stall_gen++;
      end
      drain();

      // Reset mid-stream with results in flight
      lat_mode = 1'b1;
      for (int i = 0; i < 6; i++) send_rand();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_sum", 64'(bus.sum), 64'd0);
      chk("midrst_cout", 64'(bus.cout), 64'd0);
      chk("midrst_ovf", 64'(bus.ovf), 64'd0);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_stale_valid", 64'(bus.out_valid), 64'd0);
      end

      // Random traffic with bubbles and random backpressure
      lat_mode = 1'b0;
      rmode    = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         send_rand();
      end
      drain();
      rmode = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
